cu_fsm_mc: RTL and testbench
============================

Name: cu_fsm_mc

Overview:
- Parametrised multi-cycle control unit for the DLX-style datapath.
- Accepts one instruction (opcode/func) through a valid/ready handshake and sequences it through DECODE, EXECUTE, MEMORY and WRITEBACK.
- Drives the 13 datapath control signals as one packed control word, with memory wait-state handling, illegal-opcode detection and a memory timeout.

Parameters:
- FUNC_SIZE, 11: width of func field.
- OP_CODE_SIZE, 6: width of opcode field.
- CW_SIZE, 13: control-word width. Must be >= 13; bits above 12 are driven 0.
- WAIT_MAX, 15: maximum MEMORY wait cycles before timeout. Must be >= 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  an instruction is presented on opcode/func.
- instr_ready  out  1  the FSM can accept an instruction.
- opcode  in  OP_CODE_SIZE  instruction opcode.
- func  in  FUNC_SIZE  R-type function field.
- mem_ready  in  1  data memory completes the current access.
- cw  out  CW_SIZE  control word: [12]rf1 [11]rf2 [10]en1 [9]s1 [8]s2 [7]alu1 [6]alu2 [5]en2 [4]rm [3]wm [2]en3 [1]s3 [0]wf1.
- busy  out  1  FSM is not in IDLE.
- done  out  1  1-cycle pulse on instruction retirement.
- illegal  out  1  1-cycle pulse on an unsupported opcode/func.
- mem_timeout  out  1  1-cycle pulse when the memory wait exceeds WAIT_MAX.

Behaviour:
- Reset: state=IDLE, cw=0, instr_ready=1, busy=0, done=0, illegal=0, mem_timeout=0, wait counter=0, latched opcode/func=0.
- Reset asserted mid-instruction aborts it; no done pulse is produced.
- States: IDLE, DECODE, EXECUTE, MEMORY, WRITEBACK. instr_ready=1 only in IDLE; busy=!IDLE.
- Accept: instr_valid && instr_ready at a clock edge latches opcode/func and moves to DECODE. opcode/func are ignored afterwards.
- Decoded classes (all other combinations are illegal):
  - RTYPE: opcode 0x00 with func 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR.
  - ADDI 0x08, LW 0x23, SW 0x2B, NOP 0x15.
- ALU code {alu1,alu2}: ADD=00, SUB=01, AND=10, OR=11. ADDI, LW and SW use ADD.
- DECODE: rf1=1, en1=1; rf2=1 for RTYPE/SW, else 0.
  - Illegal: cw=0, illegal pulses this cycle, next state IDLE.
  - Otherwise next state EXECUTE.
- EXECUTE: en2=1, s1=1; s2=0 for RTYPE, 1 for ADDI/LW/SW; ALU code as above.
- MEMORY: en3=1; rm=1 for LW, wm=1 for SW.
  - RTYPE/ADDI: single cycle, then WRITEBACK.
  - LW/SW: hold in MEMORY, cw held stable, until mem_ready=1, then leave. mem_ready sampled in the same cycle counts.
  - Wait counter counts MEMORY cycles without mem_ready. If it reaches WAIT_MAX with mem_ready still 0: mem_timeout pulses that cycle, cw=0 on the next cycle, next state IDLE, no done. mem_ready=1 in the WAIT_MAX-th cycle wins over timeout.
  - SW leaving MEMORY: done pulses in that MEMORY cycle, next state IDLE (no WRITEBACK).
- WRITEBACK: wf1=1; s3=1 for LW, 0 otherwise. done pulses; next state IDLE.
- NOP: traverses all states with cw=0; done pulses in WRITEBACK.
- Latency (accept edge = cycle 0): RTYPE/ADDI/NOP retire in cycle 4. LW retires in cycle 4+w, where w = mem_ready wait cycles. SW retires in cycle 3+w.
- cw, done, illegal and mem_timeout are combinational from the state register and latched instruction; no output glitches are permitted across a state boundary.
- Back-to-back operation: the next instruction is acceptable in the IDLE cycle immediately following retirement; throughput is one instruction per (latency+1) cycles.
- Unused cw bits [CW_SIZE-1:13] are always 0.

Optional Feature:
- Macro CU_FSM_OUT_REG_EN.
- Defined: cw, done, illegal and mem_timeout are registered. Each appears one cycle later than the timing above; state sequencing and instr_ready/busy are unchanged; registered values reset to 0.
- Undefined: combinational outputs exactly as specified above.

Test Plan:
- Reset then RTYPE ADD (opcode 0x00, func 0x20) -> cw in cycles 1..4 = 0x1C00, 0x0220, 0x0004, 0x0001; done in cycle 4; instr_ready=1 again in cycle 5.
- LW (0x23), mem_ready low 3 cycles then high -> EXECUTE cw=0x0320, MEMORY cw=0x0014 held 4 cycles, WRITEBACK cw=0x0003, done in cycle 7.
- SW (0x2B), mem_ready=1 immediately -> DECODE cw=0x1C00, MEMORY cw=0x000C, done in cycle 3, no WRITEBACK.
- Opcode 0x3F, then opcode 0x00 with func 0x07 -> each: illegal pulse in cycle 1, cw=0, back to IDLE in cycle 2, no done.
- LW with mem_ready held 0 and WAIT_MAX=15 -> mem_timeout pulse in the 15th MEMORY cycle, then IDLE, no done, no wf1.
- rst asserted during EXECUTE of ADDI (0x08) -> next cycle: IDLE, cw=0, done=0, instr_ready=1.

Source files
------------

// File: rtl/cu_fsm_mc.sv
// Multi-cycle DLX control unit: sequences one instruction through DECODE/EXECUTE/MEMORY/WRITEBACK.
// Define CU_FSM_OUT_REG_EN to register cw/done/illegal/mem_timeout (one cycle later).
module cu_fsm_mc #(
  parameter int FUNC_SIZE    = 11,
  parameter int OP_CODE_SIZE = 6,
  parameter int CW_SIZE      = 13,
  parameter int WAIT_MAX     = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [OP_CODE_SIZE-1:0] opcode,
  input  logic [FUNC_SIZE-1:0]    func,
  input  logic                    mem_ready,
  output logic [CW_SIZE-1:0]      cw,
  output logic                    busy,
  output logic                    done,
  output logic                    illegal,
  output logic                    mem_timeout
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  localparam logic [OP_CODE_SIZE-1:0] OP_RTYPE = OP_CODE_SIZE'('h00);
  localparam logic [OP_CODE_SIZE-1:0] OP_ADDI  = OP_CODE_SIZE'('h08);
  localparam logic [OP_CODE_SIZE-1:0] OP_NOP   = OP_CODE_SIZE'('h15);
  localparam logic [OP_CODE_SIZE-1:0] OP_LW    = OP_CODE_SIZE'('h23);
  localparam logic [OP_CODE_SIZE-1:0] OP_SW    = OP_CODE_SIZE'('h2B);

  localparam logic [FUNC_SIZE-1:0] FN_ADD = FUNC_SIZE'('h20);
  localparam logic [FUNC_SIZE-1:0] FN_SUB = FUNC_SIZE'('h22);
  localparam logic [FUNC_SIZE-1:0] FN_AND = FUNC_SIZE'('h24);
  localparam logic [FUNC_SIZE-1:0] FN_OR  = FUNC_SIZE'('h25);

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK
  } state_t;

  state_t                  state, nxt;
  logic [OP_CODE_SIZE-1:0] op_q;
  logic [FUNC_SIZE-1:0]    fn_q;
  logic [CNT_W-1:0]        wcnt;

  logic       is_rtype, is_addi, is_lw, is_sw, is_nop, legal;
  logic [1:0] alu;

  logic [12:0]        cw_c;
  logic [CW_SIZE-1:0] cw_full;
  logic               done_c, ill_c, to_c;

  // Instruction class decode from the latched fields
  always_comb begin
    is_rtype = 1'b0;
    is_addi  = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_nop   = 1'b0;
    alu      = ALU_ADD;
    case (op_q)
      OP_RTYPE: begin
        is_rtype = 1'b1;
        case (fn_q)
          FN_ADD:  alu = ALU_ADD;
          FN_SUB:  alu = ALU_SUB;
          FN_AND:  alu = ALU_AND;
          FN_OR:   alu = ALU_OR;
          default: is_rtype = 1'b0;
        endcase
      end
      OP_ADDI: is_addi = 1'b1;
      OP_LW:   is_lw   = 1'b1;
      OP_SW:   is_sw   = 1'b1;
      OP_NOP:  is_nop  = 1'b1;
      default: ;
    endcase
    legal = is_rtype | is_addi | is_lw | is_sw | is_nop;
  end

  always_comb begin
    nxt    = state;
    cw_c   = '0;
    done_c = 1'b0;
    ill_c  = 1'b0;
    to_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (instr_valid) nxt = S_DECODE;
      end
      S_DECODE: begin
        if (!legal) begin
          ill_c = 1'b1;
          nxt   = S_IDLE;
        end else begin
          if (!is_nop) begin
            cw_c[12] = 1'b1;
            cw_c[11] = is_rtype | is_sw;
            cw_c[10] = 1'b1;
          end
          nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (!is_nop) begin
          cw_c[9]   = 1'b1;
          cw_c[8]   = ~is_rtype;
          cw_c[7:6] = alu;
          cw_c[5]   = 1'b1;
        end
        nxt = S_MEMORY;
      end
      S_MEMORY: begin
        if (!is_nop) begin
          cw_c[4] = is_lw;
          cw_c[3] = is_sw;
          cw_c[2] = 1'b1;
        end
        if (is_lw || is_sw) begin
          // mem_ready in the last allowed wait cycle still completes the access
          if (mem_ready) begin
            done_c = is_sw;
            nxt    = is_sw ? S_IDLE : S_WRITEBACK;
          end else if (wcnt == CNT_W'(WAIT_MAX - 1)) begin
            to_c = 1'b1;
            nxt  = S_IDLE;
          end
        end else begin
          nxt = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        if (!is_nop) begin
          cw_c[1] = is_lw;
          cw_c[0] = 1'b1;
        end
        done_c = 1'b1;
        nxt    = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_q  <= '0;
      fn_q  <= '0;
      wcnt  <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && instr_valid) begin
        op_q <= opcode;
        fn_q <= func;
      end
      if (state == S_MEMORY && nxt == S_MEMORY) wcnt <= wcnt + 1'b1;
      else                                      wcnt <= '0;
    end
  end

  always_comb begin
    cw_full       = '0;
    cw_full[12:0] = cw_c;
  end

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);

`ifdef CU_FSM_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cw          <= '0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      cw          <= cw_full;
      done        <= done_c;
      illegal     <= ill_c;
      mem_timeout <= to_c;
    end
  end
`else
  assign cw          = cw_full;
  assign done        = done_c;
  assign illegal     = ill_c;
  assign mem_timeout = to_c;
`endif

endmodule

// File: tb/tb_cu_fsm_mc.sv
// Self-checking bench for cu_fsm_mc: per-instruction expected traces built from the ISA rules.
module tb_cu_fsm_mc;

  localparam int FS   = 11;
  localparam int OS   = 6;
  localparam int CWS  = 13;
  localparam int WMAX = 15;
`ifdef CU_FSM_OUT_REG_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif

  logic           clk;
  logic           rst;
  logic           instr_valid;
  logic           instr_ready;
  logic [OS-1:0]  opcode;
  logic [FS-1:0]  func;
  logic           mem_ready;
  logic [CWS-1:0] cw;
  logic           busy;
  logic           done;
  logic           illegal;
  logic           mem_timeout;

  cu_fsm_mc #(
    .FUNC_SIZE(FS),
    .OP_CODE_SIZE(OS),
    .CW_SIZE(CWS),
    .WAIT_MAX(WMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .opcode(opcode),
    .func(func),
    .mem_ready(mem_ready),
    .cw(cw),
    .busy(busy),
    .done(done),
    .illegal(illegal),
    .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [12:0] cw;
    logic        done;
    logic        ill;
    logic        to;
  } exp_t;

  exp_t exq[$];
  int   cur_cls;

  // cls: 0 illegal, 1 rtype, 2 addi, 3 lw, 4 sw, 5 nop
  function automatic void decode_ref(input logic [5:0] op, input logic [10:0] fn,
                                     output int cls, output logic [1:0] aluc);
    cls  = 0;
    aluc = 2'b00;
    case (op)
      6'h00: begin
        cls = 1;
        case (fn)
          11'h020: aluc = 2'b00;
          11'h022: aluc = 2'b01;
          11'h024: aluc = 2'b10;
          11'h025: aluc = 2'b11;
          default: cls = 0;
        endcase
      end
      6'h08: cls = 2;
      6'h23: cls = 3;
      6'h2B: cls = 4;
      6'h15: cls = 5;
      default: cls = 0;
    endcase
  endfunction

  function automatic exp_t mk(input logic [12:0] c, input logic d, input logic i, input logic t);
    exp_t e;
    e.cw = c; e.done = d; e.ill = i; e.to = t;
    return e;
  endfunction

  // Builds the expected per-cycle outputs; index 0 is the accepting IDLE cycle
  task automatic build(input logic [5:0] op, input logic [10:0] fn, input int w);
    int          cls;
    logic [1:0]  aluc;
    logic [12:0] mc;
    bit          nop, rt, lw, sw, fin, tout;
    int          k;
    exq.delete();
    decode_ref(op, fn, cls, aluc);
    cur_cls = cls;
    exq.push_back(mk(13'h0, 1'b0, 1'b0, 1'b0));
    if (cls == 0) begin
      exq.push_back(mk(13'h0, 1'b0, 1'b1, 1'b0));
      return;
    end
    nop = (cls == 5); rt = (cls == 1); lw = (cls == 3); sw = (cls == 4);
    exq.push_back(mk(nop ? 13'h0 : (13'h1400 | ((rt || sw) ? 13'h0800 : 13'h0)), 1'b0, 1'b0, 1'b0));
    exq.push_back(mk(nop ? 13'h0 : (13'h0220 | (rt ? 13'h0 : 13'h0100) | (13'(aluc) << 6)),
                     1'b0, 1'b0, 1'b0));
    mc = nop ? 13'h0 : (13'h0004 | (lw ? 13'h0010 : 13'h0) | (sw ? 13'h0008 : 13'h0));
    if (lw || sw) begin
      k = 0; fin = 0; tout = 0;
      while (!fin) begin
        if (k >= w) begin
          exq.push_back(mk(mc, sw, 1'b0, 1'b0));
          fin = 1;
        end else if (k == WMAX - 1) begin
          exq.push_back(mk(mc, 1'b0, 1'b0, 1'b1));
          fin = 1; tout = 1;
        end else begin
          exq.push_back(mk(mc, 1'b0, 1'b0, 1'b0));
        end
        k++;
      end
      if (tout || sw) return;
    end else begin
      exq.push_back(mk(mc, 1'b0, 1'b0, 1'b0));
    end
    exq.push_back(mk(nop ? 13'h0 : (13'h0001 | (lw ? 13'h0002 : 13'h0)), 1'b1, 1'b0, 1'b0));
  endtask

  // Presents one instruction in the current IDLE cycle and checks every cycle until retirement
  task automatic run_instr(input logic [5:0] op, input logic [10:0] fn, input int w, input string tag);
    int   last;
    exp_t e;
    build(op, fn, w);
    last = exq.size() - 1;
    for (int k = 0; k <= last; k++) begin
      instr_valid = (k == 0) ? 1'b1 : 1'($urandom);
      opcode      = (k == 0) ? op : OS'($urandom);
      func        = (k == 0) ? fn : FS'($urandom);
      if ((cur_cls == 3 || cur_cls == 4) && k >= 3) mem_ready = ((k - 3) >= w);
      else                                          mem_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (instr_ready !== (k == 0)) begin
        errors++;
        $display("FAIL %s_ready cyc=%0d got=%b exp=%b", tag, k, instr_ready, (k == 0));
      end
      checks++;
      if (busy !== (k != 0)) begin
        errors++;
        $display("FAIL %s_busy cyc=%0d got=%b exp=%b", tag, k, busy, (k != 0));
      end
      if (k >= OFF) begin
        e = exq[k - OFF];
        checks++;
        if (cw !== CWS'(e.cw)) begin
          errors++;
          $display("FAIL %s_cw cyc=%0d got=%h exp=%h", tag, k, cw, e.cw);
        end
        checks++;
        if (done !== e.done) begin
          errors++;
          $display("FAIL %s_done cyc=%0d got=%b exp=%b", tag, k, done, e.done);
        end
        checks++;
        if (illegal !== e.ill) begin
          errors++;
          $display("FAIL %s_illegal cyc=%0d got=%b exp=%b", tag, k, illegal, e.ill);
        end
        checks++;
        if (mem_timeout !== e.to) begin
          errors++;
          $display("FAIL %s_timeout cyc=%0d got=%b exp=%b", tag, k, mem_timeout, e.to);
        end
      end
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
  endtask

  task automatic idle_cycle(input string tag);
    instr_valid = 1'b0;
    mem_ready   = 1'($urandom);
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle got=%b%b%b exp=100", tag, instr_ready, busy, done);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_valid = 1'b1;
    opcode = 6'h23;
    func = '0;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({instr_ready, busy, done, illegal, mem_timeout} !== 5'b10000 || cw !== '0) begin
      errors++;
      $display("FAIL reset got=%b%b%b%b%b cw=%h exp=10000 cw=0", instr_ready, busy, done,
               illegal, mem_timeout, cw);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    instr_valid = 1'b0;
    idle_cycle("post_reset");
  endtask

  task automatic test_rtype();
    run_instr(6'h00, 11'h020, 0, "add");
    run_instr(6'h00, 11'h022, 0, "sub");
    run_instr(6'h00, 11'h024, 0, "and");
    run_instr(6'h00, 11'h025, 0, "or");
    idle_cycle("rtype_end");
  endtask

  task automatic test_mem();
    run_instr(6'h23, 11'h000, 3, "lw_w3");
    run_instr(6'h2B, 11'h000, 0, "sw_w0");
    run_instr(6'h2B, 11'h3FF, 2, "sw_w2");
    run_instr(6'h08, 11'h000, 0, "addi");
    run_instr(6'h15, 11'h000, 0, "nop");
    idle_cycle("mem_end");
  endtask

  task automatic test_illegal();
    run_instr(6'h3F, 11'h000, 0, "ill_op");
    run_instr(6'h00, 11'h007, 0, "ill_fn");
    run_instr(6'h00, 11'h420, 0, "ill_fnhi");
    idle_cycle("ill_end");
  endtask

  task automatic test_timeout();
    run_instr(6'h23, 11'h000, WMAX, "lw_to");
    run_instr(6'h23, 11'h000, WMAX - 1, "lw_lastwin");
    run_instr(6'h2B, 11'h000, WMAX + 3, "sw_to");
    run_instr(6'h2B, 11'h000, WMAX - 1, "sw_lastwin");
    idle_cycle("to_end");
  endtask

  task automatic test_midreset();
    instr_valid = 1'b1; opcode = 6'h08; func = '0; mem_ready = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({instr_ready, busy, done} !== 3'b100 || cw !== '0) begin
      errors++;
      $display("FAIL midreset got=%b%b%b cw=%h exp=100 cw=0", instr_ready, busy, done, cw);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) idle_cycle("midreset_after");
  endtask

  task automatic test_back_to_back();
    logic [5:0]  op;
    logic [10:0] fn;
    int          sel;
    logic [10:0] rfn[4];
    rfn[0] = 11'h020; rfn[1] = 11'h022; rfn[2] = 11'h024; rfn[3] = 11'h025;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 7);
      fn  = FS'($urandom);
      case (sel)
        0, 1: begin op = 6'h00; fn = rfn[$urandom_range(0, 3)]; end
        2: op = 6'h08;
        3: op = 6'h23;
        4: op = 6'h2B;
        5: op = 6'h15;
        default: op = OS'($urandom);
      endcase
      run_instr(op, fn, $urandom_range(0, WMAX + 2), "rand");
    end
    idle_cycle("rand_end");
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; opcode = '0; func = '0; mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_mem();
    test_illegal();
    test_timeout();
    test_midreset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
